// File: rtl/dcache_qspi.sv
// dcache_qspi: moves one cache line at a time between the data cache and a
// quad-SPI PSRAM running in QPI mode. A fill (pull) reads 2*LINE_LENGTH
// nibbles from the device and hands them to the cache on wstrobe_d/dread.
// A writeback (push) takes nibbles from the cache on rstrobe_d/dwrite and
// shifts them out to the device.
//
// Optional build macro DCACHE_QSPI_QPI_ENTER_EN: after reset the block first
// sends the "enter QPI mode" opcode (0x35) in single-bit SPI mode on
// io_out[0], then waits the chip-select gap before accepting requests.
// Without the macro the device is assumed to be in QPI mode already, and the
// block sits in IDLE from the first cycle after reset.

module dcache_qspi #(
  parameter int         LINE_LENGTH = 4,
  parameter int         PA          = 22,
  parameter int         DUMMY       = 7,
  parameter logic [7:0] CMD_READ    = 8'hEB,
  parameter logic [7:0] CMD_WRITE   = 8'h38,
  parameter int         CS_GAP      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_push,
  input  logic                              req_pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] req_tag,
  output logic                              busy,
  output logic                              done,
  output logic [3:0]                        dread,
  output logic                              wstrobe_d,
  input  logic [3:0]                        dwrite,
  output logic                              rstrobe_d,
  output logic                              cs_n,
  output logic                              sclk_en,
  output logic [3:0]                        io_out,
  output logic                              io_oe,
  input  logic [3:0]                        io_in
);

  // Address and burst geometry.
  localparam int OB        = $clog2(LINE_LENGTH);
  localparam int TW        = PA - OB;
  localparam int BURST     = 2 * LINE_LENGTH;
  // A write spends one extra DATA cycle so the last registered nibble is
  // clocked out while cs_n is still low.
  localparam int WR_LEN    = BURST + 1;
  localparam int DUMMY_CYC = DUMMY - 1;
  localparam int INIT_LEN  = 8 + CS_GAP;

  // The shared phase counter is sized for the longest phase.
  localparam int MAX_A  = (WR_LEN > DUMMY_CYC) ? WR_LEN : DUMMY_CYC;
  localparam int MAX_B  = (INIT_LEN > CS_GAP) ? INIT_LEN : CS_GAP;
  localparam int MAX_PH = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = $clog2(MAX_PH);

  // Last counter value of each phase.
  localparam logic [CW-1:0] CMD_LAST   = CW'(1);
  localparam logic [CW-1:0] ADDR_LAST  = CW'(5);
  localparam logic [CW-1:0] DUMMY_LAST = CW'(DUMMY_CYC - 1);
  localparam logic [CW-1:0] WR_LAST    = CW'(BURST);
  localparam logic [CW-1:0] RD_LAST    = CW'(BURST - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

  // FSM encoding.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
`ifdef DCACHE_QSPI_QPI_ENTER_EN
  localparam logic [2:0] S_INIT  = 3'd6;
  localparam logic [2:0] S_RESET = S_INIT;
  // INIT: 8 single-bit opcode cycles with cs_n low, then the cs_n gap.
  localparam logic [CW-1:0] INIT_SPI_END = CW'(8);
  localparam logic [CW-1:0] INIT_LAST    = CW'(INIT_LEN - 1);
  localparam logic [7:0]    CMD_QPI_ON   = 8'h35;
`else
  localparam logic [2:0] S_RESET = S_IDLE;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kind_w_q, kind_w_d;   // 1: writeback (push), 0: fill (pull)
  logic [TW-1:0] tag_q, tag_d;
  logic [3:0]    wdata_q;              // writeback nibble, one cycle behind its strobe
  logic [3:0]    dread_q;              // io_in input register

  logic [7:0]    opcode;
  logic [23:0]   addr_w;
  logic [23:0]   addr_sh;

  // Opcode and byte address for the current line, address sent MS nibble first.
  assign opcode  = kind_w_q ? CMD_WRITE : CMD_READ;
  assign addr_w  = 24'({tag_q, {OB{1'b0}}});
  assign addr_sh = addr_w << {cnt_q, 2'b00};

`ifdef DCACHE_QSPI_QPI_ENTER_EN
  logic [7:0] qpi_sh;
  assign qpi_sh = CMD_QPI_ON << cnt_q[2:0];
`endif

  // Next-state logic: phase sequencing and request capture in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    kind_w_d = kind_w_q;
    tag_d    = tag_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Push wins over pull when both are requested.
        if (req_push) begin
          kind_w_d = 1'b1;
          tag_d    = req_tag;
          state_d  = S_CMD;
        end else if (req_pull) begin
          kind_w_d = 1'b0;
          tag_d    = req_tag;
          state_d  = S_CMD;
        end
      end
      S_CMD: begin
        if (cnt_q == CMD_LAST) begin
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = (kind_w_q || (DUMMY_CYC == 0)) ? S_DATA : S_DUMMY;
        end
      end
      S_DUMMY: begin
        if (cnt_q == DUMMY_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // The data counter only wraps by leaving DATA.
        if ((kind_w_q && (cnt_q == WR_LAST)) || (!kind_w_q && (cnt_q == RD_LAST))) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
`ifdef DCACHE_QSPI_QPI_ENTER_EN
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      kind_w_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kind_w_q <= kind_w_d;
      tag_q    <= tag_d;
    end
  end

  // Data registers: writeback nibble captured on its strobe, io_in sampled every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdata_q <= 4'h0;
      dread_q <= 4'h0;
    end else begin
      if (rstrobe_d) begin
        wdata_q <= dwrite;
      end
      dread_q <= io_in;
    end
  end

  // Pin and strobe decode from the current phase.
  always_comb begin
    cs_n      = 1'b1;
    sclk_en   = 1'b0;
    io_oe     = 1'b0;
    io_out    = 4'h0;
    wstrobe_d = 1'b0;
    rstrobe_d = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_CMD: begin
        cs_n    = 1'b0;
        sclk_en = 1'b1;
        io_oe   = 1'b1;
        io_out  = (cnt_q == '0) ? opcode[7:4] : opcode[3:0];
      end
      S_ADDR: begin
        cs_n    = 1'b0;
        sclk_en = 1'b1;
        io_oe   = 1'b1;
        io_out  = addr_sh[23:20];
      end
      S_DUMMY: begin
        cs_n    = 1'b0;
        sclk_en = 1'b1;
      end
      S_DATA: begin
        cs_n = 1'b0;
        if (kind_w_q) begin
          // No device clock on the first cycle: wdata_q holds nothing new yet.
          io_oe     = 1'b1;
          io_out    = wdata_q;
          rstrobe_d = (cnt_q < WR_LAST);
          sclk_en   = (cnt_q != '0);
        end else begin
          // The final nibble is already in the input register, so stop SCLK.
          wstrobe_d = 1'b1;
          sclk_en   = (cnt_q != RD_LAST);
        end
      end
      S_GAP: begin
        done = (cnt_q == GAP_LAST);
      end
`ifdef DCACHE_QSPI_QPI_ENTER_EN
      S_INIT: begin
        if (cnt_q < INIT_SPI_END) begin
          cs_n    = 1'b0;
          sclk_en = 1'b1;
          io_oe   = 1'b1;
          io_out  = {3'b000, qpi_sh[7]};
        end
      end
`endif
      default: begin
        cs_n = 1'b1;
      end
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign dread = dread_q;

endmodule

// File: tb/tb_dcache_qspi.sv
// Directed bench for dcache_qspi (LINE_LENGTH=4, PA=22, DUMMY=7, CS_GAP=2).
// Cycle n is counted from the cycle t in which the request is presented in IDLE.
// Outputs are sampled 1 time unit after the rising edge.

module tb_dcache_qspi;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_push;
  logic        req_pull;
  logic [19:0] req_tag;
  logic        busy, done, wstrobe_d, rstrobe_d, cs_n, sclk_en, io_oe;
  logic [3:0]  dread, dwrite, io_out;
  logic [3:0]  io_in = 4'h0;
  logic [3:0]  woff = 4'h0;
  int          ccnt = 0;
  int          total = 0;
  int          bad = 0;

`ifdef DCACHE_QSPI_QPI_ENTER_EN
  localparam logic EB = 1'b1;
`else
  localparam logic EB = 1'b0;
`endif

  dcache_qspi dut (
    .clk(clk), .reset(reset), .req_push(req_push), .req_pull(req_pull),
    .req_tag(req_tag), .busy(busy), .done(done), .dread(dread),
    .wstrobe_d(wstrobe_d), .dwrite(dwrite), .rstrobe_d(rstrobe_d),
    .cs_n(cs_n), .sclk_en(sclk_en), .io_out(io_out), .io_oe(io_oe),
    .io_in(io_in)
  );

  always #5 clk = ~clk;

  // Cache side: burst offset counter, writeback data is offset+1 (0x1..0x8).
  always @(posedge clk) begin
    if (reset || done) woff <= 4'h0;
    else if (rstrobe_d) woff <= woff + 4'd1;
  end
  assign dwrite = woff + 4'd1;

  // PSRAM model: counts chip-select-low cycles and drives the read nibbles
  // 0xA..0x3 during cs-low cycles 14..21 (command 2 + address 6 + wait states).
  always @(negedge clk) begin
    if (cs_n !== 1'b0) ccnt = 0;
    else ccnt++;
    io_in = (ccnt >= 14 && ccnt <= 21) ? 4'(24 - ccnt) : 4'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    reset = 1'b1; req_push = 1'b0; req_pull = 1'b0; req_tag = '0;
    tick(); tick();
    got = {cs_n, sclk_en, io_oe, io_out, dread, wstrobe_d, rstrobe_d, done, busy};
    exp = {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, EB};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL reset_values got=%h want=%h", got, exp);
    end
    reset = 1'b0;
    if (EB) repeat (10) tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy got=%b want=0", busy);
    end
    $display("reset: checked");
  endtask

  task automatic test_push();
    logic [6:0] got, exp;
    logic [3:0] e_io;
    logic       e_sclk;
    req_tag = 20'h15; req_push = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n == 1) req_push = 1'b0;
      e_sclk = (n <= 8) || (n >= 10 && n <= 17);
      exp = {(n > 17), e_sclk, (n <= 17), (n >= 9 && n <= 16), 1'b0, (n == 19), (n <= 19)};
      got = {cs_n, sclk_en, io_oe, rstrobe_d, wstrobe_d, done, busy};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL push_ctrl n=%0d got=%b want=%b", n, got, exp);
      end
      if (e_sclk) begin
        case (n)
          1: e_io = 4'h3;
          2: e_io = 4'h8;
          3, 4, 5, 6: e_io = 4'h0;
          7: e_io = 4'h5;
          8: e_io = 4'h4;
          default: e_io = 4'(n - 9);
        endcase
        total++;
        if (io_out !== e_io) begin
          bad++; $display("FAIL push_io n=%0d got=%h want=%h", n, io_out, e_io);
        end
      end
    end
    $display("push: tag=0x15 done");
  endtask

  task automatic test_pull(input string name);
    logic [6:0] got, exp;
    logic [3:0] e_io;
    req_tag = 20'h3; req_pull = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      tick();
      if (n == 1) req_pull = 1'b0;
      exp = {(n > 22), (n <= 21), (n <= 8), 1'b0, (n >= 15 && n <= 22), (n == 24), (n <= 24)};
      got = {cs_n, sclk_en, io_oe, rstrobe_d, wstrobe_d, done, busy};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL %s_ctrl n=%0d got=%b want=%b", name, n, got, exp);
      end
      if (n <= 8) begin
        case (n)
          1: e_io = 4'hE;
          2: e_io = 4'hB;
          8: e_io = 4'hC;
          default: e_io = 4'h0;
        endcase
        total++;
        if (io_out !== e_io) begin
          bad++; $display("FAIL %s_io n=%0d got=%h want=%h", name, n, io_out, e_io);
        end
      end
      if (n >= 15 && n <= 22) begin
        total++;
        if (dread !== 4'(25 - n)) begin
          bad++; $display("FAIL %s_dread n=%0d got=%h want=%h", name, n, dread, 4'(25 - n));
        end
      end
    end
    $display("%s: tag=0x3 done", name);
  endtask

  task automatic test_back_to_back();
    req_tag = 20'h15; req_push = 1'b1; req_pull = 1'b1;
    for (int n = 1; n <= 46; n++) begin
      tick();
      if (n == 1) req_push = 1'b0;
      if (n == 9) begin
        total++;
        if ({rstrobe_d, wstrobe_d} !== 2'b10) begin
          bad++; $display("FAIL b2b_push_first got=%b want=10", {rstrobe_d, wstrobe_d});
        end
      end
      if (n == 17 || n == 18 || n == 19) begin
        total++;
        if (cs_n !== (n != 17)) begin
          bad++; $display("FAIL b2b_cs n=%0d got=%b want=%b", n, cs_n, (n != 17));
        end
      end
      if (n == 20) begin
        total++;
        if ({cs_n, busy} !== 2'b10) begin
          bad++; $display("FAIL b2b_idle got=%b want=10", {cs_n, busy});
        end
      end
      if (n == 21) begin
        total++;
        if ({cs_n, io_out} !== {1'b0, 4'hE}) begin
          bad++; $display("FAIL b2b_pull_start got=%b/%h want=0/e", cs_n, io_out);
        end
        req_pull = 1'b0;
      end
      if (n == 35) begin
        total++;
        if ({wstrobe_d, dread} !== {1'b1, 4'hA}) begin
          bad++; $display("FAIL b2b_dread got=%b/%h want=1/a", wstrobe_d, dread);
        end
      end
      if (n == 44 || n == 46) begin
        total++;
        if ({done, busy} !== ((n == 44) ? 2'b11 : 2'b00)) begin
          bad++; $display("FAIL b2b_end n=%0d got=%b", n, {done, busy});
        end
      end
    end
    $display("back_to_back: push then pull done");
  endtask

  task automatic test_hold_gap();
    req_tag = 20'h3; req_pull = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      tick();
      if (n == 15) begin
        total++;
        if ({wstrobe_d, dread} !== {1'b1, 4'hA}) begin
          bad++; $display("FAIL hold_dread got=%b/%h want=1/a", wstrobe_d, dread);
        end
      end
      if (n == 23 || n == 24) begin
        total++;
        if ({cs_n, busy, done} !== {2'b11, (n == 24)}) begin
          bad++; $display("FAIL hold_gap n=%0d got=%b want=11%b", n, {cs_n, busy, done}, (n == 24));
        end
      end
      if (n == 24) req_pull = 1'b0;
      if (n == 25 || n == 26) begin
        total++;
        if ({cs_n, busy} !== 2'b10) begin
          bad++; $display("FAIL hold_idle n=%0d got=%b want=10", n, {cs_n, busy});
        end
      end
    end
    $display("hold_gap: no retrigger");
  endtask

  task automatic test_reset_mid();
    req_tag = 20'h3; req_pull = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (n == 1) req_pull = 1'b0;
    end
    total++;
    if ({wstrobe_d, dread} !== {1'b1, 4'h6}) begin
      bad++; $display("FAIL rstmid_nib4 got=%b/%h want=1/6", wstrobe_d, dread);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({cs_n, wstrobe_d, busy} !== {1'b1, 1'b0, EB}) begin
      bad++; $display("FAIL rstmid_abort got=%b want=10%b", {cs_n, wstrobe_d, busy}, EB);
    end
    reset = 1'b0;
    if (EB) repeat (10) tick();
    $display("reset_mid: aborted, reissuing");
    test_pull("pull_after_reset");
  endtask

`ifdef DCACHE_QSPI_QPI_ENTER_EN
  task automatic test_qpi_enter();
    logic [7:0] seq;
    seq = 8'h35;
    reset = 1'b1; req_pull = 1'b0; req_push = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c <= 35; c++) begin
      if (c > 0) tick();
      if (c < 8) begin
        total++;
        if ({cs_n, io_out[0], busy} !== {1'b0, seq[7 - c], 1'b1}) begin
          bad++; $display("FAIL qpi_bit c=%0d got=%b want=0%b1", c, {cs_n, io_out[0], busy}, seq[7 - c]);
        end
      end
      if (c == 2) begin
        req_tag = 20'h3; req_pull = 1'b1;
      end
      if (c == 8 || c == 9) begin
        total++;
        if ({cs_n, busy} !== 2'b11) begin
          bad++; $display("FAIL qpi_gap c=%0d got=%b want=11", c, {cs_n, busy});
        end
      end
      if (c == 10) begin
        total++;
        if (busy !== 1'b0) begin
          bad++; $display("FAIL qpi_idle got=%b want=0", busy);
        end
      end
      if (c == 11) begin
        total++;
        if ({cs_n, io_out} !== {1'b0, 4'hE}) begin
          bad++; $display("FAIL qpi_served got=%b/%h want=0/e", cs_n, io_out);
        end
        req_pull = 1'b0;
      end
      if (c == 34) begin
        total++;
        if (done !== 1'b1) begin
          bad++; $display("FAIL qpi_done got=%b want=1", done);
        end
      end
    end
    $display("qpi_enter: 0x35 sent, held request served");
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_push = 1'b0; req_pull = 1'b0; req_tag = '0;
    test_reset();
`ifdef DCACHE_QSPI_QPI_ENTER_EN
    test_qpi_enter();
`endif
    test_push();
    test_pull("pull");
    test_back_to_back();
    test_hold_gap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_qspi.md
# dcache_qspi

Line-transfer sequencer between the data cache and an external quad-SPI PSRAM. It accepts one line fill (pull) or line writeback (push) request at a time and runs the QPI command, address, dummy and data phases. Data moves to and from the cache as a burst of consecutive one-nibble strobes: `wstrobe_d`/`dread` for fills, `rstrobe_d`/`dwrite` for writebacks. It sits directly downstream of the cache's `hit`/`push`/`pull`/`tag` outputs and owns the PSRAM pins.

## Interface
- LINE_LENGTH, 4: cache line length in bytes; the burst is 2*LINE_LENGTH nibbles.
- PA, 22: physical address width; PA must be ≤ 24.
- DUMMY, 7: number of clk cycles from the last address nibble to the first `wstrobe_d`. Covers device wait states and the input register.
- CMD_READ, 8'hEB: QPI fast quad read opcode.
- CMD_WRITE, 8'h38: QPI quad write opcode.
- CS_GAP, 2: minimum number of cycles `cs_n` stays high between transactions.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_push  in  1  write back the line `req_tag`; caller qualifies it with a valid access.
- req_pull  in  1  fill the line `req_tag`.
- req_tag  in  PA-log2(LINE_LENGTH)  line address, i.e. the cache `tag` output.
- busy  out  1  block is not in IDLE.
- done  out  1  one-cycle pulse when a transaction completes.
- dread  out  4  fill nibble to the cache; valid with `wstrobe_d`.
- wstrobe_d  out  1  fill strobe.
- dwrite  in  4  writeback nibble from the cache; combinational from the cache burst offset.
- rstrobe_d  out  1  writeback strobe.
- cs_n  out  1  PSRAM chip select, active low.
- sclk_en  out  1  the pad forms SCLK = `sclk_en` & ~clk.
- io_out  out  4  PSRAM data out.
- io_oe  out  1  output enable for `io_out`.
- io_in  in  4  PSRAM data in; registered inside the block.

## Operation
- Byte address is {zeros, req_tag, log2(LINE_LENGTH) zeros}, 24 bits, sent most significant nibble first as 6 nibbles.
- States: INIT (present only with the macro), IDLE, CMD, ADDR, DUMMY, DATA, GAP.
- IDLE: if `req_push` is high, latch the tag and kind=write. Otherwise if `req_pull` is high, latch the tag and kind=read. Push takes priority. Next state is CMD.
- CMD, 2 cycles: `cs_n`=0, `sclk_en`=1, `io_oe`=1, opcode sent high nibble first.
- ADDR, 6 cycles. Next state is DATA for a write, DUMMY for a read.
- DUMMY, DUMMY-1 cycles: `io_oe`=0, `sclk_en`=1.
- DATA, 2*LINE_LENGTH cycles.
  - Write: `rstrobe_d`=1 on every DATA cycle. `io_out` is driven from `dwrite` as a registered value, so the device sees nibble k one cycle after strobe k. SCLK runs one extra cycle to clock out the last nibble.
  - Read: `wstrobe_d`=1 on every DATA cycle and `dread` = registered `io_in`. SCLK stops after the device has supplied the last nibble.
- Strobes are consecutive with no gaps; the cache's offset counter depends on this.
- GAP, CS_GAP cycles: `cs_n`=1, `io_oe`=0. `done`=1 on the last GAP cycle, then IDLE.
- Requests are ignored outside IDLE. The cache drops push/pull one cycle after the final strobe; GAP covers that window, so no spurious retrigger.

## Timing
- Reset values: `cs_n`=1, `sclk_en`=0, `io_oe`=0, `io_out`=0, `dread`=0, strobes 0, `done`=0, `busy`=1 while in INIT and 0 otherwise.
- Request seen in IDLE at cycle t: `cs_n` falls at t+1.
- Write: strobes at t+9..t+8+2L, where L=LINE_LENGTH. `cs_n` low for 9+2L cycles. `done` at t+9+2L+CS_GAP.
- Read: first `wstrobe_d` at t+8+DUMMY.
- Back-to-back push then pull: the second `cs_n` fall comes exactly CS_GAP+1 cycles after the first `cs_n` rise.
- Reset mid-transaction: on the next cycle `cs_n`=1, strobes=0, state is INIT or IDLE. The partial line is not marked valid in the cache because the final strobe never occurred.
- Counters are log2 of the largest phase length; the data counter wraps only by leaving the DATA state.

## Configuration
- DCACHE_QSPI_QPI_ENTER_EN defined: after reset the block enters INIT and sends 0x35 in single-bit SPI mode on `io_out[0]` (8 cycles, `cs_n` low), followed by CS_GAP cycles high. `busy`=1 throughout and requests are ignored until IDLE.
- DCACHE_QSPI_QPI_ENTER_EN undefined: the device is assumed to be already in QPI mode and the block is in IDLE from the first cycle after reset.

## Test plan
- Push with req_tag=0x15 → CMD nibbles 3,8. Address nibbles 0,0,0,0,5,4. Eight `rstrobe_d` cycles, and `io_out` replays `dwrite` 0x1..0x8 delayed one cycle. `done` at t+19 (CS_GAP=2).
- Pull with tag=0x3 and PSRAM model returning 0xA..0x3 → nibbles E,B, then address. First `wstrobe_d` at t+15. `dread` sequence 0xA..0x3 on consecutive cycles.
- Push and pull high together → push runs first. Pull starts with `cs_n` falling 3 cycles after the push's `cs_n` rise.
- Reset asserted during read DATA nibble 4 → next cycle `cs_n`=1, `wstrobe_d`=0, `busy`=0; the request is reissued afterwards.
- With DCACHE_QSPI_QPI_ENTER_EN: `io_out[0]` carries 0,0,1,1,0,1,0,1. A `req_pull` at cycle 2 is held off until IDLE and then served.
- `req_pull` held high through GAP → no second transaction starts before IDLE.
